hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have ports id_rs and id_rt, input, 5 bits each: source registers of the instruction in ID.
REQ-004 SHALL have port id_dst, input, 5 bits: destination of the ID instruction, already selected by RegDst.
REQ-005 SHALL have ports id_MemRead, id_RegWrite and id_Jump, input, 1 bit each: decoder outputs for the ID instruction.
REQ-006 SHALL have port ex_branch_taken, input, 1 bit: branch in EX resolved taken (Beq/bne outcome).
REQ-007 SHALL have ports mem_req and mem_ready, input, 1 bit each: MEM-stage access active; memory completes this cycle.
REQ-008 SHALL have ports pc_write and ifid_write, output, 1 bit each: enables for the PC and IF/ID registers.
REQ-009 SHALL have ports if_flush and idex_bubble, output, 1 bit each: IF/ID and ID/EX register loads a NOP.
REQ-010 SHALL have port freeze, output, 1 bit: holds every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
REQ-011 SHALL have port mem_timeout, output, 1 bit: sticky error flag.
REQ-012 SHALL have ports stall_cnt and flush_cnt, output, 16 bits each: saturating performance counters.

Function
REQ-013 SHALL keep an EX shadow (ex_MemRead, ex_RegWrite, ex_dst[4:0]) mirroring the ID/EX register contents.
REQ-014 SHALL implement FSM states RUN and MEM_WAIT.
REQ-015 SHALL transition RUN->MEM_WAIT when mem_req=1 and mem_ready=0.
REQ-016 SHALL transition MEM_WAIT->RUN when mem_ready=1.
REQ-017 SHALL remain in the current state in all other cases.
REQ-018 SHALL drive freeze = mem_req & ~mem_ready combinationally, in either state.
REQ-019 SHALL define load_use = ex_MemRead & (ex_dst!=0) & (ex_dst==id_rs | ex_dst==id_rt).
REQ-020 SHALL apply output priority in the order: freeze, then ex_branch_taken, then load_use, then id_Jump.
REQ-021 SHALL, when freeze=1, set pc_write=0, ifid_write=0, if_flush=0 and idex_bubble=0, and hold the shadow.
REQ-022 SHALL, when branch-taken (no freeze), set pc_write=1, ifid_write=1, if_flush=1 and idex_bubble=1, and load the shadow with the bubble.
REQ-023 SHALL, when load_use (no freeze, no branch), set pc_write=0, ifid_write=0 and idex_bubble=1, and load the shadow with the bubble.
REQ-024 SHALL ensure a load-use stall lasts exactly one cycle, because the bubble clears ex_MemRead.
REQ-025 SHALL, when id_Jump only, set pc_write=1, ifid_write=1, if_flush=1 and idex_bubble=0, and load the shadow from the id_* inputs.
REQ-026 SHALL otherwise set pc_write=1, ifid_write=1, if_flush=0 and idex_bubble=0, and load the shadow from the id_* inputs.
REQ-027 SHALL define the bubble as MemRead=0, RegWrite=0 and dst=0.
REQ-028 SHALL keep an 8-bit wait counter that counts up each cycle in MEM_WAIT with mem_ready=0.
REQ-029 SHALL clear the wait counter on leaving MEM_WAIT.
REQ-030 SHALL set mem_timeout when the wait counter reaches 255, hold it until rst, and stay in MEM_WAIT (no abort).
REQ-031 SHALL increment stall_cnt each cycle in which freeze=1 or the load-use stall is applied, saturating at 0xFFFF.
REQ-032 SHALL increment flush_cnt by 1 each cycle in which if_flush=1, saturating at 0xFFFF.

Reset
REQ-033 SHALL, at a clock edge with rst=1, set state=RUN, clear the shadow, the wait counter, mem_timeout, stall_cnt and flush_cnt.
REQ-034 SHALL, while rst=1, force pc_write=0, ifid_write=0, if_flush=1, idex_bubble=1 and freeze=0, regardless of other inputs.
REQ-035 SHALL, when rst is asserted during MEM_WAIT, abandon the wait: RUN at the next edge and timeout not flagged.

Verification
REQ-036 SHALL cover load-use: lw with id_dst=8, then id_rs=8 -> one cycle of pc_write=0 and idex_bubble=1, normal next cycle, stall_cnt=1.
REQ-037 SHALL cover a $0 hazard: lw with id_dst=0, then id_rt=0 -> no stall, stall_cnt=0.
REQ-038 SHALL cover a branch and jump: ex_branch_taken=1 while id_Jump=1 -> if_flush=1 and idex_bubble=1, flush_cnt increments by 1 (not 2).
REQ-039 SHALL cover memory wait: mem_req=1 with mem_ready low for 3 cycles -> freeze=1 for 3 cycles, RUN after ready, stall_cnt=3.
REQ-040 SHALL cover memory timeout: mem_ready low for 300 cycles -> mem_timeout rises after 255 wait cycles and stays set; rst clears it.
REQ-041 SHALL cover reset mid-wait: rst pulse in MEM_WAIT -> RUN, both counters 0, reset-value outputs during rst.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/freeze control with EX shadow, memory-wait FSM and perf counters
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_dst,
  input  logic        id_MemRead,
  input  logic        id_RegWrite,
  input  logic        id_Jump,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        if_flush,
  output logic        idex_bubble,
  output logic        freeze,
  output logic        mem_timeout,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  state_t      state_q, state_d;
  logic        ex_mem_read_q, ex_mem_read_d, ex_reg_write_q, ex_reg_write_d;
  logic [4:0]  ex_dst_q, ex_dst_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic        mem_stall, load_use, bubble, stall;
  always_comb begin
    mem_stall      = mem_req & ~mem_ready;
    load_use       = ex_mem_read_q & (ex_dst_q != 5'd0) & ((ex_dst_q == id_rs) | (ex_dst_q == id_rt));
    bubble         = ex_branch_taken | load_use;
    stall          = mem_stall | (~ex_branch_taken & load_use);
    freeze         = ~rst & mem_stall;
    pc_write       = ~rst & ~mem_stall & (ex_branch_taken | ~load_use);
    ifid_write     = pc_write;
    if_flush       = rst | (~mem_stall & (ex_branch_taken | (~load_use & id_Jump)));
    idex_bubble    = rst | (~mem_stall & bubble);
    state_d        = (state_q == RUN && mem_stall) ? MEM_WAIT :
                     (state_q == MEM_WAIT && mem_ready) ? RUN : state_q;
    ex_mem_read_d  = mem_stall ? ex_mem_read_q  : ~bubble & id_MemRead;
    ex_reg_write_d = mem_stall ? ex_reg_write_q : ~bubble & id_RegWrite;
    ex_dst_d       = mem_stall ? ex_dst_q : (bubble ? 5'd0 : id_dst);
    // counter parks at 255 so the timeout stays meaningful while the wait continues
    wait_cnt_d     = (state_q != MEM_WAIT || mem_ready) ? 8'd0 :
                     (wait_cnt_q == 8'hff) ? wait_cnt_q : wait_cnt_q + 8'd1;
    mem_timeout_d  = mem_timeout_q | (wait_cnt_d == 8'hff);
    stall_cnt_d    = (stall && stall_cnt_q != 16'hffff) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    flush_cnt_d    = (if_flush && flush_cnt_q != 16'hffff) ? flush_cnt_q + 16'd1 : flush_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      ex_mem_read_q  <= 1'b0;
      ex_reg_write_q <= 1'b0;
      ex_dst_q       <= 5'd0;
      wait_cnt_q     <= 8'd0;
      mem_timeout_q  <= 1'b0;
      stall_cnt_q    <= 16'd0;
      flush_cnt_q    <= 16'd0;
    end else begin
      state_q        <= state_d;
      ex_mem_read_q  <= ex_mem_read_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_dst_q       <= ex_dst_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cnt_q    <= stall_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end
  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
endmodule
